// File: rtl/b200_reset_sequencer.sv
// b200 clock-ready and reset sequencer: lock monitoring, hold-off,
// staged reset release, glitch-filtered relock and lock-loss telemetry.
module b200_reset_sequencer #(
    parameter int NUM_LOCKS      = 2,
    parameter int NUM_RESETS     = 3,
    parameter int HOLDOFF_CYCLES = 65536,
    parameter int STAGE_DELAY    = 16,
    parameter int GLITCH_CYCLES  = 4
) (
    input  logic                  bus_clk,
    input  logic                  reset_global,
    input  logic [NUM_LOCKS-1:0]  lock_in,
    input  logic [NUM_LOCKS-1:0]  lock_mask,
    input  logic                  force_reset,
    input  logic                  clear_sticky,
    output logic [NUM_RESETS-1:0] rst_out,
    output logic                  clocks_ready,
    output logic [1:0]            state,
    output logic [7:0]            lock_loss_cnt,
    output logic [NUM_LOCKS-1:0]  lock_sticky
);

    localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam int SW = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;
    localparam int GW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;
    localparam int IW = $clog2(NUM_RESETS + 1);

    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLDOFF_CYCLES - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(STAGE_DELAY - 1);
    localparam logic [GW-1:0] GLITCH_LAST = GW'(GLITCH_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_RESETS);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLDOFF   = 2'd1,
        RELEASE   = 2'd2,
        READY     = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [NUM_LOCKS-1:0]  sync1_q, lock_sync;
    logic [HW-1:0]         hold_q, hold_d;
    logic [SW-1:0]         stage_q, stage_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [GW-1:0]         filt_q, filt_d;
    logic [NUM_RESETS-1:0] rst_q, rst_d;
    logic                  ready_q, ready_d;
    logic [7:0]            loss_q, loss_d;
    logic [NUM_LOCKS-1:0]  sticky_q, sticky_d, sticky_set;
    logic                  all_locked, active, lost, abort;

    // lock_in is asynchronous; only lock_sync is used downstream
    always_ff @(posedge bus_clk or posedge reset_global) begin
        if (reset_global) begin
            sync1_q   <= '0;
            lock_sync <= '0;
        end else begin
            sync1_q   <= lock_in;
            lock_sync <= sync1_q;
        end
    end

    assign all_locked = &(lock_sync | lock_mask);
    assign active     = (state_q == RELEASE) || (state_q == READY);
    assign lost       = active && !all_locked && (filt_q == GLITCH_LAST);
    assign abort      = (state_q != WAIT_LOCK) && (state_d == WAIT_LOCK);

    always_ff @(posedge bus_clk or posedge reset_global) begin
        if (reset_global) begin
            state_q  <= WAIT_LOCK;
            hold_q   <= '0;
            stage_q  <= '0;
            idx_q    <= '0;
            filt_q   <= '0;
            rst_q    <= '1;
            ready_q  <= 1'b0;
            loss_q   <= '0;
            sticky_q <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            stage_q  <= stage_d;
            idx_q    <= idx_d;
            filt_q   <= filt_d;
            rst_q    <= rst_d;
            ready_q  <= ready_d;
            loss_q   <= loss_d;
            sticky_q <= sticky_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_LOCK: begin
                if (all_locked) state_d = HOLDOFF;
            end
            HOLDOFF: begin
                if (!all_locked || force_reset) state_d = WAIT_LOCK;
                else if (hold_q == HOLD_LAST) state_d = RELEASE;
            end
            RELEASE: begin
                if (lost || force_reset) state_d = WAIT_LOCK;
                else if (stage_q == STAGE_LAST && idx_q == IDX_LAST)
                    state_d = READY;
            end
            READY: begin
                if (lost || force_reset) state_d = WAIT_LOCK;
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    always_comb begin
        hold_d  = hold_q;
        stage_d = stage_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        ready_d = ready_q;
        filt_d  = '0;
        if (active && !all_locked && !abort) filt_d = filt_q + 1'b1;
        if (abort || state_q == WAIT_LOCK) begin
            hold_d  = '0;
            stage_d = '0;
            idx_d   = '0;
            rst_d   = '1;
            ready_d = 1'b0;
        end else if (state_q == HOLDOFF) begin
            if (state_d == RELEASE) begin
                hold_d   = '0;
                stage_d  = '0;
                idx_d    = IW'(1);
                rst_d[0] = 1'b0;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end else if (state_q == RELEASE) begin
            if (stage_q == STAGE_LAST) begin
                stage_d = '0;
                if (idx_q == IDX_LAST) begin
                    ready_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                    for (int k = 0; k < NUM_RESETS; k++)
                        if (IW'(k) == idx_q) rst_d[k] = 1'b0;
                end
            end else begin
                stage_d = stage_q + 1'b1;
            end
        end
    end

    // a new low sample outranks a simultaneous clear
    always_comb begin
        sticky_set = ~lock_sync & ~lock_mask & {NUM_LOCKS{active}};
        sticky_d   = clear_sticky ? sticky_set : (sticky_q | sticky_set);
        loss_d     = loss_q;
        if (lost && loss_q != 8'hFF) loss_d = loss_q + 8'd1;
    end

    assign rst_out       = rst_q;
    assign clocks_ready  = ready_q;
    assign state         = state_q;
    assign lock_loss_cnt = loss_q;
    assign lock_sticky   = sticky_q;

endmodule

// File: tb/tb_b200_reset_sequencer.sv
// Directed self-checking bench for b200_reset_sequencer
// (hold-off 8, stage delay 4, 3 resets, glitch 3, 2 locks).
module tb_b200_reset_sequencer;

    logic       bus_clk = 1'b0;
    logic       reset_global = 1'b0;
    logic [1:0] lock_in = 2'b00;
    logic [1:0] lock_mask = 2'b00;
    logic       force_reset = 1'b0;
    logic       clear_sticky = 1'b0;
    logic [2:0] rst_out;
    logic       clocks_ready;
    logic [1:0] state;
    logic [7:0] lock_loss_cnt;
    logic [1:0] lock_sticky;

    int checks = 0;
    int errors = 0;

    b200_reset_sequencer #(
        .NUM_LOCKS(2),
        .NUM_RESETS(3),
        .HOLDOFF_CYCLES(8),
        .STAGE_DELAY(4),
        .GLITCH_CYCLES(3)
    ) dut (
        .bus_clk(bus_clk),
        .reset_global(reset_global),
        .lock_in(lock_in),
        .lock_mask(lock_mask),
        .force_reset(force_reset),
        .clear_sticky(clear_sticky),
        .rst_out(rst_out),
        .clocks_ready(clocks_ready),
        .state(state),
        .lock_loss_cnt(lock_loss_cnt),
        .lock_sticky(lock_sticky)
    );

    always #5 bus_clk = ~bus_clk;

    task automatic tick();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic restart(input logic [1:0] locks, input logic [1:0] mask);
        reset_global = 1'b1;
        lock_in = locks;
        lock_mask = mask;
        force_reset = 1'b0;
        clear_sticky = 1'b0;
        tick();
        tick();
        reset_global = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget,
                              output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (state == s) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        #2 reset_global = 1'b1;
        #1;
        checks++;
        if (state !== 2'd0 || rst_out !== 3'b111 || clocks_ready !== 1'b0 ||
            lock_loss_cnt !== 8'd0 || lock_sticky !== 2'b00) begin
            errors++;
            $display("FAIL reset st=%0d rst=%b rdy=%b cnt=%0d stk=%b exp 0 111 0 0 00",
                     state, rst_out, clocks_ready, lock_loss_cnt, lock_sticky);
        end
        tick();
        reset_global = 1'b0;
    endtask

    task automatic test_power_up();
        logic [1:0] es;
        logic [2:0] er;
        restart(2'b00, 2'b00);
        lock_in = 2'b11;
        for (int e = 1; e <= 23; e++) begin
            tick();
            es = (e < 3) ? 2'd0 : (e < 11) ? 2'd1 : (e < 23) ? 2'd2 : 2'd3;
            er = (e < 11) ? 3'b111 : (e < 15) ? 3'b110 :
                 (e < 19) ? 3'b100 : 3'b000;
            checks++;
            if (state !== es || rst_out !== er || clocks_ready !== (e >= 23)) begin
                errors++;
                $display("FAIL power_up e=%0d st=%0d rst=%b rdy=%b exp %0d %b %0d",
                         e, state, rst_out, clocks_ready, es, er, e >= 23);
            end
        end
    endtask

    task automatic test_holdoff_restart();
        logic [1:0] es;
        logic [2:0] er;
        restart(2'b11, 2'b00);
        for (int e = 1; e <= 29; e++) begin
            tick();
            if (e == 5) lock_in = 2'b01;
            if (e == 6) lock_in = 2'b11;
            es = (e < 3) ? 2'd0 : (e < 8) ? 2'd1 : (e == 8) ? 2'd0 :
                 (e < 17) ? 2'd1 : (e < 29) ? 2'd2 : 2'd3;
            er = (e < 17) ? 3'b111 : (e < 21) ? 3'b110 :
                 (e < 25) ? 3'b100 : 3'b000;
            checks++;
            if (state !== es || rst_out !== er || clocks_ready !== (e >= 29)) begin
                errors++;
                $display("FAIL holdoff e=%0d st=%0d rst=%b rdy=%b exp %0d %b %0d",
                         e, state, rst_out, clocks_ready, es, er, e >= 29);
            end
            if (e == 8) begin
                checks++;
                if (lock_loss_cnt !== 8'd0) begin
                    errors++;
                    $display("FAIL holdoff_cnt got %0d exp 0", lock_loss_cnt);
                end
            end
        end
    endtask

    task automatic test_glitch();
        lock_in = 2'b10;
        tick();
        tick();
        lock_in = 2'b11;
        for (int j = 2; j <= 5; j++) begin
            tick();
            checks++;
            if (clocks_ready !== 1'b1 || state !== 2'd3) begin
                errors++;
                $display("FAIL glitch_short L+%0d rdy=%b st=%0d exp 1 3",
                         j, clocks_ready, state);
            end
        end
        checks++;
        if (lock_sticky !== 2'b01 || lock_loss_cnt !== 8'd0) begin
            errors++;
            $display("FAIL glitch_sticky stk=%b cnt=%0d exp 01 0",
                     lock_sticky, lock_loss_cnt);
        end
        lock_in = 2'b10;
        tick();
        tick();
        tick();
        lock_in = 2'b11;
        tick();
        checks++;
        if (clocks_ready !== 1'b1 || state !== 2'd3) begin
            errors++;
            $display("FAIL glitch_L3 rdy=%b st=%0d exp 1 3", clocks_ready, state);
        end
        tick();
        checks++;
        if (rst_out !== 3'b111 || clocks_ready !== 1'b0 || state !== 2'd0 ||
            lock_loss_cnt !== 8'd1) begin
            errors++;
            $display("FAIL glitch_abort rst=%b rdy=%b st=%0d cnt=%0d exp 111 0 0 1",
                     rst_out, clocks_ready, state, lock_loss_cnt);
        end
    endtask

    task automatic test_force_reset();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            tick();
            if (state == 2'd2 && rst_out == 3'b110) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL force_wait st=%0d rst=%b exp 2 110", state, rst_out);
        end
        tick();
        force_reset = 1'b1;
        tick();
        force_reset = 1'b0;
        checks++;
        if (rst_out !== 3'b111 || state !== 2'd0) begin
            errors++;
            $display("FAIL force_abort rst=%b st=%0d exp 111 0", rst_out, state);
        end
        tick();
        checks++;
        if (state !== 2'd1 || lock_loss_cnt !== 8'd1) begin
            errors++;
            $display("FAIL force_next st=%0d cnt=%0d exp 1 1", state, lock_loss_cnt);
        end
    endtask

    task automatic test_masking();
        restart(2'b01, 2'b10);
        for (int e = 1; e <= 26; e++) begin
            tick();
            if ((e == 3 && state !== 2'd1) ||
                (e == 11 && rst_out !== 3'b110) ||
                (e == 22 && (state !== 2'd2 || clocks_ready !== 1'b0)) ||
                (e == 23 && (state !== 2'd3 || clocks_ready !== 1'b1)) ||
                (e == 26 && (lock_sticky !== 2'b00 || rst_out !== 3'b000))) begin
                errors++;
                $display("FAIL mask e=%0d st=%0d rst=%b rdy=%b stk=%b",
                         e, state, rst_out, clocks_ready, lock_sticky);
            end
            if (e == 3 || e == 11 || e == 22 || e == 23 || e == 26) checks++;
        end
        lock_mask = 2'b00;
        tick();
        tick();
        checks++;
        if (state !== 2'd3 || lock_sticky !== 2'b10) begin
            errors++;
            $display("FAIL unmask_m1 st=%0d stk=%b exp 3 10", state, lock_sticky);
        end
        tick();
        checks++;
        if (state !== 2'd0 || lock_loss_cnt !== 8'd1 || rst_out !== 3'b111) begin
            errors++;
            $display("FAIL unmask_abort st=%0d cnt=%0d rst=%b exp 0 1 111",
                     state, lock_loss_cnt, rst_out);
        end
    endtask

    task automatic test_saturation();
        bit ok1, ok2;
        restart(2'b00, 2'b00);
        for (int i = 1; i <= 257; i++) begin
            lock_in = 2'b11;
            wait_state(2'd2, 40, ok1);
            lock_in = 2'b00;
            wait_state(2'd0, 10, ok2);
            if (!ok1 || !ok2) begin
                checks++;
                errors++;
                $display("FAIL sat_wait iter=%0d st=%0d", i, state);
                break;
            end
            if (i == 254 || i == 255 || i == 257) begin
                checks++;
                if (lock_loss_cnt !== ((i == 254) ? 8'd254 : 8'd255)) begin
                    errors++;
                    $display("FAIL sat_cnt iter=%0d got %0d", i, lock_loss_cnt);
                end
            end
        end
        lock_in = 2'b11;
        wait_state(2'd2, 40, ok1);
        clear_sticky = 1'b1;
        tick();
        clear_sticky = 1'b0;
        checks++;
        if (!ok1 || lock_sticky !== 2'b00) begin
            errors++;
            $display("FAIL sticky_clear ok=%0d stk=%b exp 1 00", ok1, lock_sticky);
        end
        lock_in = 2'b10;
        tick();
        tick();
        clear_sticky = 1'b1;
        tick();
        clear_sticky = 1'b0;
        checks++;
        if (lock_sticky !== 2'b01 || state !== 2'd2) begin
            errors++;
            $display("FAIL sticky_prio stk=%b st=%0d exp 01 2", lock_sticky, state);
        end
        tick();
        tick();
        checks++;
        if (state !== 2'd0 || lock_loss_cnt !== 8'd255) begin
            errors++;
            $display("FAIL sat_hold st=%0d cnt=%0d exp 0 255", state, lock_loss_cnt);
        end
    endtask

    task automatic test_async_reset();
        restart(2'b11, 2'b00);
        for (int e = 1; e <= 24; e++) tick();
        #3 reset_global = 1'b1;
        #1;
        checks++;
        if (state !== 2'd0 || rst_out !== 3'b111 || clocks_ready !== 1'b0 ||
            lock_sticky !== 2'b00) begin
            errors++;
            $display("FAIL async_reset st=%0d rst=%b rdy=%b stk=%b exp 0 111 0 00",
                     state, rst_out, clocks_ready, lock_sticky);
        end
        tick();
        reset_global = 1'b0;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_holdoff_restart();
        test_glitch();
        test_force_reset();
        test_masking();
        test_saturation();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/b200_reset_sequencer.md
# b200_reset_sequencer

Parametrised clock-ready and reset sequencer for the b200 top level. It replaces the single fixed 16-bit hold-off counter with:

- synchronised monitoring of multiple PLL/lock inputs, with per-input masking;
- a programmable hold-off followed by staged release of N ordered resets;
- glitch-filtered relock handling;
- lock-loss telemetry.

Its outputs drive the downstream reset_sync instances and the readback registers.

## Interface

Parameters:

- NUM_LOCKS, 2: number of lock inputs monitored.
- NUM_RESETS, 3: number of sequenced reset outputs; bit 0 is released first.
- HOLDOFF_CYCLES, 65536: cycles all locks must stay high before release starts; must be ≥1.
- STAGE_DELAY, 16: cycles between successive reset releases; must be ≥1.
- GLITCH_CYCLES, 4: consecutive low cycles that count as a lock loss after hold-off; must be ≥1.

Ports:

- bus_clk, in, 1: clock.
- reset_global, in, 1: reset, asynchronous, active-high.
- lock_in, in, NUM_LOCKS: raw lock indicators, asynchronous to bus_clk.
- lock_mask, in, NUM_LOCKS: 1 ignores that lock bit (quasi-static, bus_clk domain).
- force_reset, in, 1: single-cycle request to restart the sequence.
- clear_sticky, in, 1: clears lock_sticky.
- rst_out, out, NUM_RESETS: sequenced resets, active-high.
- clocks_ready, out, 1: all resets released and locks stable.
- state, out, 2: 0 WAIT_LOCK, 1 HOLDOFF, 2 RELEASE, 3 READY.
- lock_loss_cnt, out, 8: saturating count of filtered lock losses.
- lock_sticky, out, NUM_LOCKS: per-bit sticky record of unmasked low samples seen in RELEASE/READY.

## Operation

**Synchronisation**
- Each lock_in bit passes through a 2-FF synchroniser to give lock_sync.
- all_locked = AND over (lock_sync | lock_mask).
- All lock bits masked gives all_locked = 1.

**Abort**
- An abort is any transition into WAIT_LOCK from another state.
- On the abort edge: all rst_out bits go to 1, clocks_ready goes to 0, and all internal counters clear.

**State machine** (all outputs registered)
- WAIT_LOCK: all rst_out = 1, clocks_ready = 0. When all_locked = 1, go to HOLDOFF with holdoff count = 0.
- HOLDOFF:
  - all_locked = 0 on any single cycle: go to WAIT_LOCK. No loss is counted.
  - Otherwise the count increments each edge.
  - On the edge where count == HOLDOFF_CYCLES-1: go to RELEASE and clear rst_out[0] on that same edge (edge E0).
- RELEASE:
  - rst_out[k] clears at edge E0 + k·STAGE_DELAY.
  - At edge E0 + NUM_RESETS·STAGE_DELAY: go to READY and set clocks_ready = 1.
- READY: holds until an abort.

**Loss filter** (RELEASE/READY only)
- The filter counts consecutive cycles with all_locked = 0; any high sample resets it to 0.
- On an edge where all_locked = 0 and filter == GLITCH_CYCLES-1:
  - abort to WAIT_LOCK;
  - increment lock_loss_cnt, saturating at 255.
- With GLITCH_CYCLES = 1, the first low sample aborts.

**force_reset**
- In HOLDOFF, RELEASE or READY: abort to WAIT_LOCK on the next edge. lock_loss_cnt is not incremented.
- In WAIT_LOCK: ignored.
- If force_reset and a filtered loss occur on the same edge, the loss is counted (cnt +1).

**lock_sticky**
- Bit i sets when lock_sync[i] = 0, lock_mask[i] = 0 and state ∈ {RELEASE, READY}.
- Cleared by clear_sticky; a set on the same edge wins over the clear.
- Not cleared by an abort.

**Masks**
- A mask change takes effect on the next edge.
- Unmasking a low lock in READY begins filtering immediately.

## Timing

- Reset values: state = 0, rst_out = all ones, clocks_ready = 0, lock_loss_cnt = 0, lock_sticky = 0, synchronisers = 0, counters = 0.
- reset_global assertion takes effect asynchronously. Deassertion is used directly on the bus_clk domain; the reset_sync stages downstream handle synchronisation.
- Lock-in to all_locked latency: 2 edges.
- Full sequence from the first edge at which lock_in is sampled high (edge 1):
  - HOLDOFF entered at edge 3;
  - E0 = edge 3 + HOLDOFF_CYCLES;
  - clocks_ready at E0 + NUM_RESETS·STAGE_DELAY.
- Abort latency from a lock_in low sample at edge L: abort at edge L + 1 + GLITCH_CYCLES.
- Counters are wide enough for their parameters. There is no wrap; the holdoff counter is clog2(HOLDOFF_CYCLES) bits.

## Test plan

All scenarios use HOLDOFF_CYCLES = 8, STAGE_DELAY = 4, NUM_RESETS = 3, GLITCH_CYCLES = 3, NUM_LOCKS = 2, mask = 0.

- **Power-up sequence.** Release reset_global, then raise both lock_in bits before edge 1. Required: state = 1 at edge 3, rst_out[0] falls at edge 11, rst_out[1] at 15, rst_out[2] at 19, clocks_ready = 1 and state = 3 at edge 23.
- **Hold-off restart.** Drop lock_in[1] for 1 cycle during HOLDOFF. Required: state = 0 two edges later, rst_out stays 3'b111, lock_loss_cnt = 0, and the full sequence restarts after the lock returns.
- **Glitch filter.** In READY, drop lock_in[0] for 2 cycles: clocks_ready stays 1, lock_sticky = 2'b01, cnt = 0. Then drop it for 3 cycles: abort with rst_out = 3'b111 and clocks_ready = 0 at L+4, and cnt = 1.
- **Masking.** With lock_mask = 2'b10 and lock_in[1] held at 0, the sequence completes as in power-up. lock_sticky[1] stays 0.
- **force_reset.** Pulse force_reset in RELEASE after rst_out[0] has cleared: rst_out = 3'b111 and state = 0 on the next edge, then state = 1 one edge later (locks still high), and cnt is unchanged.
- **Saturation and sticky priority.** Cause 257 filtered losses: lock_loss_cnt = 255. Assert clear_sticky on a cycle with an unmasked low sample: the sticky bit stays 1.
